// File: rtl/tpu_sram_loader_if.sv
// Byte-stream handshake carrying weight and vector operands into the loader.
// The producer drives valid/data; the loader drives ready.
interface tpu_sram_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/tpu_sram_loader.sv
// Streams K groups of ARRAY_SIZE weight bytes and K vector bytes into the TPU
// operand SRAM write ports, then pulses tpu_start once.
module tpu_sram_loader #(
    parameter int DATA_WIDTH      = 8,
    parameter int ARRAY_SIZE      = 8,
    parameter int K_ACCUM_DEPTH   = 32,
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int W_ADDR_WIDTH    = 6,
    parameter int V_ADDR_WIDTH    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    tpu_sram_loader_if.slave           s,
    output logic                       sram_wsb_w,
    output logic [W_ADDR_WIDTH-1:0]    sram_waddr_w,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata_w,
    output logic                       sram_wsb_v,
    output logic [V_ADDR_WIDTH-1:0]    sram_waddr_v,
    output logic [DATA_WIDTH-1:0]      sram_wdata_v,
    output logic                       tpu_start,
    output logic                       load_busy,
    output logic                       load_done
);

    localparam int LANE_W = $clog2(ARRAY_SIZE);
    localparam int CNT_W  = $clog2(K_ACCUM_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_V, FLUSH, START} state_t;

    state_t                     state, state_next;
    logic [LANE_W-1:0]          lane_cnt;
    logic [CNT_W-1:0]           word_cnt;
    logic [CNT_W-1:0]           vec_cnt;
    logic [SRAM_DATA_WIDTH-1:0] pack;
    logic [SRAM_DATA_WIDTH-1:0] pack_next;
    logic                       xfer;
    logic                       last_lane;
    logic                       last_word;
    logic                       last_vec;

    assign xfer      = s.s_valid && s.s_ready;
    assign last_lane = (lane_cnt == LANE_W'(ARRAY_SIZE - 1));
    assign last_word = (word_cnt == CNT_W'(K_ACCUM_DEPTH - 1));
    assign last_vec  = (vec_cnt == CNT_W'(K_ACCUM_DEPTH - 1));
    // First byte of a group ends up in the most significant lane.
    assign pack_next = {pack[SRAM_DATA_WIDTH-DATA_WIDTH-1:0], s.s_data};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next gets its default before the case, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (load_start) state_next = LOAD_W;
            LOAD_W:  if (xfer && last_lane && last_word) state_next = LOAD_V;
            LOAD_V:  if (xfer && last_vec) state_next = FLUSH;
            FLUSH:   state_next = START;
            START:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs are registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s.s_ready <= 1'b0;
            load_busy <= 1'b0;
            tpu_start <= 1'b0;
            load_done <= 1'b0;
        end else begin
            s.s_ready <= (state_next == LOAD_W) || (state_next == LOAD_V);
            load_busy <= (state_next != IDLE);
            tpu_start <= (state_next == START);
            if (state == IDLE && load_start) load_done <= 1'b0;
            else if (state == START)         load_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt     <= '0;
            word_cnt     <= '0;
            vec_cnt      <= '0;
            pack         <= '0;
            sram_wsb_w   <= 1'b1;
            sram_waddr_w <= '0;
            sram_wdata_w <= '0;
            sram_wsb_v   <= 1'b1;
            sram_waddr_v <= '0;
            sram_wdata_v <= '0;
        end else begin
            sram_wsb_w <= 1'b1;
            sram_wsb_v <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        lane_cnt <= '0;
                        word_cnt <= '0;
                        vec_cnt  <= '0;
                        pack     <= '0;
                    end
                end
                LOAD_W: begin
                    if (xfer) begin
                        pack     <= pack_next;
                        lane_cnt <= lane_cnt + 1'b1;
                        if (last_lane) begin
                            sram_wsb_w   <= 1'b0;
                            sram_waddr_w <= W_ADDR_WIDTH'(word_cnt);
                            sram_wdata_w <= pack_next;
                            word_cnt     <= word_cnt + 1'b1;
                        end
                    end
                end
                LOAD_V: begin
                    if (xfer) begin
                        sram_wsb_v   <= 1'b0;
                        sram_waddr_v <= V_ADDR_WIDTH'(vec_cnt);
                        sram_wdata_v <= s.s_data;
                        vec_cnt      <= vec_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sram_loader.sv
// Scoreboard bench for tpu_sram_loader: a driver pushes expected SRAM writes
// derived from stream positions; a negedge monitor pops and compares them.
module tb_tpu_sram_loader;

    localparam int DW  = 8;
    localparam int AS  = 8;
    localparam int K   = 32;
    localparam int SW  = 64;
    localparam int N_W = K * AS;
    localparam int N_T = N_W + K;

    typedef struct {
        int          addr;
        logic [63:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic          sram_wsb_w, sram_wsb_v, tpu_start, load_busy, load_done;
    logic [5:0]    sram_waddr_w;
    logic [SW-1:0] sram_wdata_w;
    logic [4:0]    sram_waddr_v;
    logic [DW-1:0] sram_wdata_v;

    tpu_sram_loader_if #(.DATA_WIDTH(DW)) s_if ();

    tpu_sram_loader #(
        .DATA_WIDTH(DW), .ARRAY_SIZE(AS), .K_ACCUM_DEPTH(K),
        .SRAM_DATA_WIDTH(SW), .W_ADDR_WIDTH(6), .V_ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .s(s_if),
        .sram_wsb_w(sram_wsb_w), .sram_waddr_w(sram_waddr_w), .sram_wdata_w(sram_wdata_w),
        .sram_wsb_v(sram_wsb_v), .sram_waddr_v(sram_waddr_v), .sram_wdata_v(sram_wdata_v),
        .tpu_start(tpu_start), .load_busy(load_busy), .load_done(load_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_w[$];
    wr_t         exp_v[$];
    int          exp_starts = 0;
    int          neg_cnt = 0;
    int          base = 0;
    int          w_cnt, v_cnt, start_cnt, start_rel, done_rel;
    logic        done_q = 1'b0;
    logic [7:0]  stream [N_T];
    logic [63:0] w_mem  [64];
    logic [7:0]  v_mem  [K];
    logic [63:0] w_snap [K];
    logic [7:0]  v_snap [K];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ctrl"}, {58'd0, s_if.s_ready, sram_wsb_w, sram_wsb_v, tpu_start, load_busy, load_done},
              64'b011000);
        check({name, "_wdata_w"}, sram_wdata_w, 64'd0);
        check({name, "_addr_v"}, {45'd0, sram_waddr_w, sram_waddr_v, sram_wdata_v}, 64'd0);
    endtask

    // Expected SRAM activity implied by accepting stream byte n.
    task automatic push_expected(input int n);
        wr_t e;
        if (n < N_W) begin
            if (n % AS == AS - 1) begin
                e.addr = n / AS;
                e.data = '0;
                for (int r = 0; r < AS; r++) e.data[63-8*r -: 8] = stream[e.addr*AS + r];
                exp_w.push_back(e);
            end
        end else begin
            e.addr = n - N_W;
            e.data = {56'd0, stream[n]};
            exp_v.push_back(e);
            if (n == N_T - 1) exp_starts++;
        end
    endtask

    initial begin : monitor
        int  cur;
        wr_t e;
        forever begin
            @(negedge clk);
            cur = neg_cnt;
            neg_cnt++;
            if (!rst) begin
                if (!sram_wsb_w) begin
                    w_cnt++;
                    w_mem[sram_waddr_w] = sram_wdata_w;
                    check("w_strobe_expected", 64'(exp_w.size() > 0), 64'd1);
                    if (exp_w.size() > 0) begin
                        e = exp_w.pop_front();
                        check("w_addr", 64'(sram_waddr_w), 64'(e.addr));
                        check("w_data", sram_wdata_w, e.data);
                    end
                end
                if (!sram_wsb_v) begin
                    v_cnt++;
                    v_mem[sram_waddr_v] = sram_wdata_v;
                    check("v_strobe_expected", 64'(exp_v.size() > 0), 64'd1);
                    if (exp_v.size() > 0) begin
                        e = exp_v.pop_front();
                        check("v_addr", 64'(sram_waddr_v), 64'(e.addr));
                        check("v_data", 64'(sram_wdata_v), e.data);
                    end
                end
                if (tpu_start) begin
                    start_cnt++;
                    start_rel = cur - base + 1;
                    check("start_expected", 64'(exp_starts > 0), 64'd1);
                    if (exp_starts > 0) exp_starts--;
                end
                if (load_done && !done_q) done_rel = cur - base + 1;
                done_q = load_done;
            end
        end
    end

    // Cycle numbering: cycle c is the period that follows edge c-1, edge 0
    // being the one that samples load_start.
    task automatic run_load(input int stall_pct, input int abort_after, input int ignore_at);
        int   n = 0;
        int   budget = 0;
        int   lim;
        logic xfer;
        lim = (abort_after < 0) ? N_T : abort_after;
        w_cnt = 0; v_cnt = 0; start_cnt = 0; start_rel = -1; done_rel = -1;
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); base = neg_cnt;
        #1 load_start = 1'b0;
        while (n < lim && budget < 4000) begin
            s_if.s_valid = ($urandom_range(99) >= stall_pct);
            s_if.s_data  = stream[n];
            if (n == ignore_at) load_start = 1'b1;
            @(negedge clk);
            xfer = s_if.s_valid && s_if.s_ready;
            @(posedge clk);
            #1 load_start = 1'b0;
            if (xfer) begin
                push_expected(n);
                if (n == ignore_at) ignore_at = -1;
                n++;
            end
            budget++;
        end
        s_if.s_valid = 1'b0;
        check("bytes_delivered", 64'(n), 64'(lim));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && !load_done; i++) @(negedge clk);
        #1;
        check({name, "_load_done"}, 64'(load_done), 64'd1);
        check({name, "_busy_idle"}, 64'(load_busy), 64'd0);
        check({name, "_w_drained"}, 64'(exp_w.size()), 64'd0);
        check({name, "_v_drained"}, 64'(exp_v.size()), 64'd0);
        check({name, "_w_strobes"}, 64'(w_cnt), 64'(K));
        check({name, "_v_strobes"}, 64'(v_cnt), 64'(K));
        check({name, "_one_start"}, 64'(start_cnt), 64'd1);
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < K; k++)
            for (int r = 0; r < AS; r++) stream[k*AS + r] = 8'((r*32 + k) % 256);
        for (int i = 0; i < K; i++) stream[N_W + i] = 8'(i + 1);
    endtask

    task automatic compare_snapshot(input string name);
        int mism = 0;
        for (int k = 0; k < K; k++) begin
            if (w_mem[k] !== w_snap[k]) mism++;
            if (v_mem[k] !== v_snap[k]) mism++;
        end
        check(name, 64'(mism), 64'd0);
    endtask

    initial begin
        int y_exp, y_dut, bad;
        rst = 1'b1;
        load_start = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        for (int i = 0; i < 64; i++) w_mem[i] = '0;
        for (int i = 0; i < K; i++) v_mem[i] = '0;
        #3 check_reset("reset_initial");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back load with the reference pattern.
        fill_pattern();
        run_load(0, -1, -1);
        wait_done("b2b");
        check("b2b_word0", w_mem[0], 64'h0020406080A0C0E0);
        check("b2b_word31", w_mem[31], 64'h1F3F5F7F9FBFDFFF);
        check("b2b_vec31", 64'(v_mem[31]), 64'h20);
        check("b2b_start_cycle", 64'(start_rel), 64'd290);
        check("b2b_done_cycle", 64'(done_rel), 64'd291);
        for (int r = 0; r < AS; r++) begin
            y_exp = 0;
            y_dut = 0;
            for (int k = 0; k < K; k++) begin
                y_exp += ((r*32 + k) % 256) * (k + 1);
                y_dut += int'(w_mem[k][63-8*r -: 8]) * int'(v_mem[k]);
            end
            check($sformatf("dot_row%0d", r), 64'(y_dut), 64'(y_exp));
        end
        for (int k = 0; k < K; k++) begin
            w_snap[k] = w_mem[k];
            v_snap[k] = v_mem[k];
        end

        // Same data with random s_valid stalls.
        for (int k = 0; k < K; k++) begin
            w_mem[k] = '0;
            v_mem[k] = '0;
        end
        run_load(40, -1, -1);
        wait_done("stall");
        compare_snapshot("stall_sram_match");

        // load_start pulsed during LOAD_V must not restart the load.
        for (int k = 0; k < K; k++) begin
            w_mem[k] = '0;
            v_mem[k] = '0;
        end
        run_load(25, -1, N_W + 14);
        wait_done("ignore");
        compare_snapshot("ignore_sram_match");

        // Reset after 100 weight bytes: no further strobes or start.
        run_load(0, 100, -1);
        repeat (2) @(negedge clk);
        check("midload_busy", 64'(load_busy), 64'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset("reset_midload");
        check("midload_no_pending_w", 64'(exp_w.size()), 64'd0);
        w_cnt = 0; v_cnt = 0; start_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("post_reset_w_strobes", 64'(w_cnt), 64'd0);
        check("post_reset_v_strobes", 64'(v_cnt), 64'd0);
        check("post_reset_no_start", 64'(start_cnt), 64'd0);

        // Fresh full load with constant bytes.
        for (int i = 0; i < N_T; i++) stream[i] = 8'h5A;
        run_load(10, -1, -1);
        wait_done("fill5a");
        bad = 0;
        for (int k = 0; k < K; k++) if (w_mem[k] !== 64'h5A5A5A5A5A5A5A5A) bad++;
        check("fill5a_words", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
